data_bus_timer: RTL and testbench

- Memory-mapped machine timer on the CPU data bus. It sits downstream of the core's data port (memRW/address/write-data out, read-data in) and upstream of the core's external interrupt input.
- Provides a prescaled 32-bit up-counter, a compare register, optional auto-reload and a sticky match flag.
- The interrupt output is the match flag gated by an enable bit.
- Read data is combinational so the single-cycle core can load it in the same cycle it presents the address.

---
 rtl/data_bus_timer_pkg.sv | 28 ++
 rtl/data_bus_timer_prescaler.sv | 50 +++++
 rtl/data_bus_timer.sv | 163 ++++++++++++++++
 tb/tb_data_bus_timer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_timer_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_timer_pkg
// Shared definitions for the memory-mapped data-bus timer:
//   - word offsets of the four registers (selected by address bits [3:2])
//   - bit positions inside the CTRL register
//   - reset value of the COMPARE register
// -----------------------------------------------------------------------------
package data_bus_timer_pkg;

  // Register select values (byte offset >> 2)
  localparam logic [1:0] TMR_CTRL    = 2'd0;  // 0x0
  localparam logic [1:0] TMR_COUNT   = 2'd1;  // 0x4
  localparam logic [1:0] TMR_COMPARE = 2'd2;  // 0x8
  localparam logic [1:0] TMR_STATUS  = 2'd3;  // 0xC

  // CTRL bit positions
  localparam int CTRL_EN           = 0;
  localparam int CTRL_IE           = 1;
  localparam int CTRL_AR           = 2;
  localparam int CTRL_PRESCALE_LSB = 8;

  // STATUS bit positions
  localparam int STATUS_MATCH = 0;

  // COMPARE resets to all-ones so a freshly reset timer does not match early
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/data_bus_timer_prescaler.sv
// -----------------------------------------------------------------------------
// data_bus_timer_prescaler
// Divides the system clock into counter ticks. While enabled, pcnt counts up
// every cycle; when it equals prescale a one-cycle tick is produced and pcnt
// returns to zero, so prescale = N yields one tick every N+1 cycles.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable (pcnt holds and no ticks while low)
//   prescale  in   terminal count
//   clr       in   synchronous clear of pcnt (any CTRL write)
//   tick      out  one-cycle counter advance strobe
// -----------------------------------------------------------------------------
module data_bus_timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_reg;
  logic [PRESCALE_W-1:0] pcnt_next;

  // Tick is judged on the current (registered) enable and pcnt; a CTRL write
  // in the same cycle only affects the following cycles.
  assign tick = en && (pcnt_reg == prescale);

  always_comb begin
    pcnt_next = pcnt_reg;
    if (clr || tick) begin
      pcnt_next = '0;
    end else if (en) begin
      pcnt_next = pcnt_reg + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_next;
    end
  end

endmodule

// File: rtl/data_bus_timer.sv
// -----------------------------------------------------------------------------
// data_bus_timer
// Memory-mapped machine timer on the CPU data bus: prescaled 32-bit up-counter,
// compare register, optional auto-reload and a sticky match flag that drives
// the core's external interrupt when enabled.
//
// Register window (16 bytes at BASE, word access, addr[1:0] ignored):
//   0x0 CTRL    [0] EN  [1] IE  [2] AR  [8 +: PRESCALE_W] PRESCALE
//   0x4 COUNT   read/write
//   0x8 COMPARE read/write
//   0xC STATUS  [0] MATCH, write 1 to clear
//
// Ports:
//   I_clk        in   system clock
//   I_rst        in   asynchronous active-low reset
//   I_memRW      in   1 = write, 0 = read
//   I_addr[31:0] in   byte address
//   I_data[31:0] in   write data
//   O_data[31:0] out  combinational read data (0 when outside the window)
//   O_hit        out  address decodes into the window
//   O_interrupt  out  MATCH & IE
// -----------------------------------------------------------------------------
module data_bus_timer
  import data_bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_1000,
  parameter int          PRESCALE_W = 8
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_memRW,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_data,
  output logic [31:0] O_data,
  output logic        O_hit,
  output logic        O_interrupt
);

  // Register state
  logic                  en_reg,       en_next;
  logic                  ie_reg,       ie_next;
  logic                  ar_reg,       ar_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [31:0]           count_reg,    count_next;
  logic [31:0]           compare_reg,  compare_next;
  logic                  match_reg,    match_next;

  // Decode
  logic [1:0] reg_sel;
  logic       wr_en;
  logic       ctrl_wr;
  logic       count_wr;
  logic       compare_wr;
  logic       status_wr;
  logic       tick;
  logic       match_set;

  // Byte-lane bits are not decoded; all accesses are full-word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^I_addr[1:0];

  assign O_hit      = (I_addr[31:4] == BASE[31:4]);
  assign reg_sel    = I_addr[3:2];
  assign wr_en      = I_memRW && O_hit;
  assign ctrl_wr    = wr_en && (reg_sel == TMR_CTRL);
  assign count_wr   = wr_en && (reg_sel == TMR_COUNT);
  assign compare_wr = wr_en && (reg_sel == TMR_COMPARE);
  assign status_wr  = wr_en && (reg_sel == TMR_STATUS);

  data_bus_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (I_clk),
    .rst_n    (I_rst),
    .en       (en_reg),
    .prescale (prescale_reg),
    .clr      (ctrl_wr),
    .tick     (tick)
  );

  // A software COUNT write overrides the tick, and suppresses match evaluation
  // for that cycle. The comparison always uses the pre-edge COMPARE value.
  assign match_set = tick && !count_wr && (count_reg == compare_reg);

  always_comb begin
    en_next       = en_reg;
    ie_next       = ie_reg;
    ar_next       = ar_reg;
    prescale_next = prescale_reg;
    count_next    = count_reg;
    compare_next  = compare_reg;
    match_next    = match_reg;

    if (ctrl_wr) begin
      en_next       = I_data[CTRL_EN];
      ie_next       = I_data[CTRL_IE];
      ar_next       = I_data[CTRL_AR];
      prescale_next = I_data[CTRL_PRESCALE_LSB +: PRESCALE_W];
    end

    if (compare_wr) begin
      compare_next = I_data;
    end

    if (count_wr) begin
      count_next = I_data;
    end else if (tick) begin
      if ((count_reg == compare_reg) && ar_reg) begin
        count_next = '0;
      end else begin
        count_next = count_reg + 32'd1;
      end
    end

    // New match takes priority over a simultaneous write-1-to-clear.
    if (match_set) begin
      match_next = 1'b1;
    end else if (status_wr && I_data[STATUS_MATCH]) begin
      match_next = 1'b0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      en_reg       <= 1'b0;
      ie_reg       <= 1'b0;
      ar_reg       <= 1'b0;
      prescale_reg <= '0;
      count_reg    <= '0;
      compare_reg  <= COMPARE_RST;
      match_reg    <= 1'b0;
    end else begin
      en_reg       <= en_next;
      ie_reg       <= ie_next;
      ar_reg       <= ar_next;
      prescale_reg <= prescale_next;
      count_reg    <= count_next;
      compare_reg  <= compare_next;
      match_reg    <= match_next;
    end
  end

  // Combinational read path so a single-cycle core can load in the same cycle.
  always_comb begin
    O_data = '0;
    if (O_hit) begin
      case (reg_sel)
        TMR_CTRL: begin
          O_data[CTRL_EN]                          = en_reg;
          O_data[CTRL_IE]                          = ie_reg;
          O_data[CTRL_AR]                          = ar_reg;
          O_data[CTRL_PRESCALE_LSB +: PRESCALE_W]  = prescale_reg;
        end
        TMR_COUNT:   O_data = count_reg;
        TMR_COMPARE: O_data = compare_reg;
        default:     O_data[STATUS_MATCH] = match_reg;
      endcase
    end
  end

  assign O_interrupt = match_reg && ie_reg;

endmodule

// File: tb/tb_data_bus_timer.sv
// -----------------------------------------------------------------------------
// tb_data_bus_timer
// Scoreboard bench for data_bus_timer. Every bus operation takes exactly one
// clock cycle (driven 1 ns after the rising edge). Read operations push the
// hand-computed expectation into a queue and raise sample_req; the monitor
// pops and compares on the falling edge of that same cycle. Cycle numbers in
// the comments count operations from the start of each phase.
// -----------------------------------------------------------------------------
module tb_data_bus_timer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        mem_rw  = 1'b0;
  logic [31:0] addr    = 32'h0000_1020;
  logic [31:0] wdata   = 32'h0;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  always #5 clk = ~clk;

  data_bus_timer #(
    .BASE       (BASE),
    .PRESCALE_W (8)
  ) dut (
    .I_clk       (clk),
    .I_rst       (rst_n),
    .I_memRW     (mem_rw),
    .I_addr      (addr),
    .I_data      (wdata),
    .O_data      (rdata),
    .O_hit       (hit),
    .O_interrupt (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        hit;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic sample_req = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: compares whatever the DUT presents against the queued expectation
  always @(negedge clk) begin
    if (sample_req) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_sample: got data=%h, required a queued expectation", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rdata === mon_e.data && hit === mon_e.hit && irq === mon_e.irq) begin
          n_pass++;
          $display("[%0t] ok   %s data=%h hit=%0b irq=%0b", $time, mon_e.name, rdata, hit, irq);
        end else begin
          $display("FAIL %s: got data=%h hit=%0b irq=%0b, required data=%h hit=%0b irq=%0b",
                   mon_e.name, rdata, hit, irq, mon_e.data, mon_e.hit, mon_e.irq);
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    mem_rw = 1'b1;
    addr   = a;
    wdata  = d;
    @(posedge clk);
    #1;
    mem_rw = 1'b0;
    addr   = BASE + 32'h20;
    $display("[%0t] wr   addr=%h data=%h", $time, a, d);
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] d,
                             input logic h, input logic i, input string nm);
    exp_t e;
    e.name = nm;
    e.data = d;
    e.hit  = h;
    e.irq  = i;
    exp_q.push_back(e);
    mem_rw     = 1'b0;
    addr       = a;
    sample_req = 1'b1;
    @(posedge clk);
    #1;
    sample_req = 1'b0;
    addr       = BASE + 32'h20;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- Phase 0: reset values while reset is held ------------
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    expect_read(BASE + 32'h0, 32'h0,         1'b1, 1'b0, "rst_ctrl");
    expect_read(BASE + 32'h4, 32'h0,         1'b1, 1'b0, "rst_count");
    expect_read(BASE + 32'h8, 32'hFFFF_FFFF, 1'b1, 1'b0, "rst_compare");
    expect_read(BASE + 32'hC, 32'h0,         1'b1, 1'b0, "rst_status");
    rst_n = 1'b1;

    // ---------------- Phase 1: basic match, prescale 0 ---------------------
    bus_write(BASE + 32'h8, 32'd3);            // c0
    bus_write(BASE + 32'h0, 32'h0000_0003);    // c1 EN|IE, ticks from c2
    for (int i = 0; i < 4; i++) begin          // c2..c5: 0,1,2,3 (match on c5)
      expect_read(BASE + 32'h4, 32'(i), 1'b1, 1'b0, $sformatf("basic_count%0d", i));
    end
    expect_read(BASE + 32'h4, 32'd4, 1'b1, 1'b1, "basic_count4_irq");   // c6
    expect_read(BASE + 32'hC, 32'd1, 1'b1, 1'b1, "basic_match");        // c7

    // ---------------- Phase 2: asynchronous reset mid-count ----------------
    rst_n = 1'b0;                              // no clock edge before sample
    expect_read(BASE + 32'h4, 32'h0,         1'b1, 1'b0, "midrst_count");
    expect_read(BASE + 32'h8, 32'hFFFF_FFFF, 1'b1, 1'b0, "midrst_compare");
    expect_read(BASE + 32'hC, 32'h0,         1'b1, 1'b0, "midrst_status");
    expect_read(BASE + 32'h0, 32'h0,         1'b1, 1'b0, "midrst_ctrl");
    rst_n = 1'b1;

    // ---------------- Phase 3: prescale 4, compare 2, auto-reload ----------
    bus_write(BASE + 32'h8, 32'd2);            // c0
    bus_write(BASE + 32'h0, 32'h0000_0407);    // c1 EN|IE|AR, PRESCALE=4
    // ticks on c6, c11, c16 (match, wrap to 0), c21, c26, c31 (match), ...
    for (int i = 0; i < 20; i++) begin         // c2..c21
      expect_read(BASE + 32'h4, 32'((i / 5) % 3), 1'b1, (i >= 15),
                  $sformatf("ar_count_c%0d", i + 2));
    end
    bus_write(BASE + 32'hC, 32'd1);            // c22 W1C
    expect_read(BASE + 32'hC, 32'd0, 1'b1, 1'b0, "ar_w1c_cleared");     // c23
    idle(8);                                   // c24..c31, wrap tick on c31
    expect_read(BASE + 32'hC, 32'd1, 1'b1, 1'b1, "ar_rematch");         // c32
    expect_read(BASE + 32'h4, 32'd0, 1'b1, 1'b1, "ar_count_wrapped");   // c33

    // ---------------- Phase 4: simultaneous events -------------------------
    bus_write(BASE + 32'hC, 32'd1);            // c34 clear
    expect_read(BASE + 32'hC, 32'd0, 1'b1, 1'b0, "sim_pre_clear");      // c35
    idle(10);                                  // c36..c45
    bus_write(BASE + 32'hC, 32'd1);            // c46 W1C on matching tick
    expect_read(BASE + 32'hC, 32'd1, 1'b1, 1'b1, "sim_set_beats_w1c");  // c47
    expect_read(BASE + 32'h4, 32'd0, 1'b1, 1'b1, "sim_count_reload");   // c48
    idle(2);                                   // c49..c50
    bus_write(BASE + 32'h4, 32'd100);          // c51 COUNT write on tick
    expect_read(BASE + 32'h4, 32'd100, 1'b1, 1'b1, "sim_write_beats_tick"); // c52
    expect_read(BASE + 32'h4, 32'd100, 1'b1, 1'b1, "sim_write_hold");       // c53

    // ---------------- Phase 5: wrap without auto-reload --------------------
    bus_write(BASE + 32'h0, 32'h0);            // c54 stop
    bus_write(BASE + 32'h4, 32'hFFFF_FFFE);    // c55
    bus_write(BASE + 32'h8, 32'h0);            // c56
    bus_write(BASE + 32'hC, 32'd1);            // c57 clear MATCH
    bus_write(BASE + 32'h0, 32'h0000_0003);    // c58 EN|IE, PRESCALE=0
    expect_read(BASE + 32'h4, 32'hFFFF_FFFE, 1'b1, 1'b0, "wrap_fffffffe");  // c59
    expect_read(BASE + 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b0, "wrap_ffffffff");  // c60
    expect_read(BASE + 32'h4, 32'h0,         1'b1, 1'b0, "wrap_zero");      // c61
    expect_read(BASE + 32'h4, 32'h1,         1'b1, 1'b1, "wrap_one_irq");   // c62

    // ---------------- Phase 6: decode and interrupt gating -----------------
    bus_write(BASE + 32'h0, 32'h0000_0002);    // IE only, counter stopped
    bus_write(BASE + 32'h4, 32'h0000_1234);
    expect_read(BASE + 32'h10, 32'h0, 1'b0, 1'b1, "dec_out_of_window");
    bus_write(BASE + 32'h14, 32'h0000_0055);   // outside window: ignored
    bus_write(BASE + 32'h10, 32'h0);
    bus_write(BASE + 32'h1C, 32'h1);
    expect_read(BASE + 32'h6, 32'h0000_1234, 1'b1, 1'b1, "dec_count_lowbits");
    expect_read(BASE + 32'h0, 32'h0000_0002, 1'b1, 1'b1, "dec_ctrl_kept");
    expect_read(BASE + 32'hE, 32'h0000_0001, 1'b1, 1'b1, "dec_status_kept");
    bus_write(BASE + 32'h0, 32'hFFFF_FFF8);    // IE=0, unmapped bits dropped
    expect_read(BASE + 32'h0, 32'h0000_FF00, 1'b1, 1'b0, "ctrl_unmapped_bits");
    expect_read(BASE + 32'hC, 32'h0000_0001, 1'b1, 1'b0, "ie0_masks_irq");
    expect_read(BASE + 32'h8, 32'h0,         1'b1, 1'b0, "compare_kept");

    // ---------------- Wrap-up ----------------------------------------------
    idle(2);
    n_total++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
